// File: rtl/cvw_pkg.sv
// Shared configuration types, frame-builder state encoding and frame geometry helpers.
package cvw;

  typedef struct packed {
    logic [31:0] XLEN;
  } cvw_t;

  localparam cvw_t CVW_RV64 = '{XLEN: 32'd64};
  localparam int   HDR_BITS = 112;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } rvvi_state_e;

  function automatic int rvvi_width(input int xlen, input int max_csrs);
    return 72 + 5 * xlen + max_csrs * (xlen + 16);
  endfunction

  function automatic int frame_bytes(input int rvvi_w);
    return (HDR_BITS + rvvi_w + 7) / 8;
  endfunction

  function automatic int frame_beats(input int fbytes, input int data_w);
    return (fbytes + data_w / 8 - 1) / (data_w / 8);
  endfunction

  // Number of valid bytes carried by the final beat.
  function automatic int last_strb_bytes(input int fbytes, input int data_w);
    int rem;
    rem = fbytes % (data_w / 8);
    return (rem == 0) ? data_w / 8 : rem;
  endfunction

endpackage

// File: rtl/rvvi_frame_builder_fifo.sv
// Record buffer: power-of-two circular FIFO; a pop frees the slot for a same-cycle push.
module rvvi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/rvvi_frame_builder.sv
// Packs buffered RVVI retire records behind an Ethernet header and streams them as AXI write beats.
module rvvi_frame_builder
  import cvw::*;
#(
  parameter cvw_t          P             = CVW_RV64,
  parameter integer        MAX_CSRS      = 3,
  parameter integer        DATA_W        = 32,
  parameter integer        FIFO_DEPTH    = 4,
  parameter logic [31:0]   INIT_TIME_OUT = 32'd4,
  localparam integer       RVVI_W        = rvvi_width(int'(P.XLEN), MAX_CSRS)
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic [RVVI_W-1:0]     rvvi,
  input  logic                  valid,
  output logic                  RVVIStall,
  output logic [DATA_W-1:0]     RvviAxiWdata,
  output logic [DATA_W/8-1:0]   RvviAxiWstrb,
  output logic                  RvviAxiWlast,
  output logic                  RvviAxiWvalid,
  input  logic                  RvviAxiWready,
  input  logic [47:0]           SrcMac,
  input  logic [47:0]           DstMac,
  input  logic [15:0]           EthType,
  input  logic [31:0]           InnerPktDelay,
  output logic [31:0]           FrameCount
);

  localparam int FRAME_BYTES = frame_bytes(RVVI_W);
  localparam int BEATS       = frame_beats(FRAME_BYTES, DATA_W);
  localparam int STRB_W      = DATA_W / 8;
  localparam int FRAME_W     = BEATS * DATA_W;
  localparam int BEAT_IW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [STRB_W-1:0] LAST_STRB =
    {STRB_W{1'b1}} >> (STRB_W - last_strb_bytes(FRAME_BYTES, DATA_W));

  rvvi_state_e          state_q, state_d;
  logic [31:0]          init_cnt_q, init_cnt_d;
  logic [31:0]          gap_cnt_q, gap_cnt_d;
  logic [31:0]          frame_count_q, frame_count_d;
  logic [BEAT_IW-1:0]   beat_q, beat_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 start_q, start_d;

  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [RVVI_W-1:0]    fifo_rdata;
  logic                 sending, is_last;

  assign sending   = (state_q == SEND);
  assign is_last   = (beat_q == BEAT_IW'(BEATS - 1));
  assign RVVIStall = (state_q == INIT) | fifo_full;
  assign fifo_push = valid & ~RVVIStall;
  assign fifo_pop  = sending & RvviAxiWready & is_last;

  rvvi_fifo #(.WIDTH(RVVI_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (m_axi_aclk),
    .rst_n (m_axi_aresetn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (rvvi),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign RvviAxiWvalid = sending;
  assign RvviAxiWlast  = sending & is_last;
  assign RvviAxiWstrb  = sending ? (is_last ? LAST_STRB : {STRB_W{1'b1}}) : '0;
  assign RvviAxiWdata  = sending ? frame_q[int'(beat_q) * DATA_W +: DATA_W] : '0;
  assign FrameCount    = frame_count_q;

  // Capture happens one cycle ahead of SEND (start_q) so the frame register settles before beat 0.
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    frame_count_d = frame_count_q;
    beat_d        = beat_q;
    frame_d       = frame_q;
    start_d       = start_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 32'd1;
        if (init_cnt_d >= INIT_TIME_OUT) state_d = IDLE;
        else                             state_d = INIT;
      end
      IDLE: begin
        if (start_q) begin
          start_d = 1'b0;
          beat_d  = '0;
          state_d = SEND;
        end else if (!fifo_empty) begin
          frame_d = FRAME_W'({fifo_rdata, EthType, DstMac, SrcMac});
          start_d = 1'b1;
        end else begin
          start_d = 1'b0;
        end
      end
      SEND: begin
        if (RvviAxiWready) begin
          if (is_last) begin
            frame_count_d = frame_count_q + 32'd1;
            beat_d        = '0;
            gap_cnt_d     = 32'd0;
            if (InnerPktDelay == 32'd0) state_d = IDLE;
            else                        state_d = GAP;
          end else begin
            beat_d = beat_q + BEAT_IW'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      GAP: begin
        if (({1'b0, gap_cnt_q} + 33'd1) >= {1'b0, InnerPktDelay}) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + 32'd1;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q       <= INIT;
      init_cnt_q    <= 32'd0;
      gap_cnt_q     <= 32'd0;
      frame_count_q <= 32'd0;
      beat_q        <= '0;
      frame_q       <= '0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_count_q <= frame_count_d;
      beat_q        <= beat_d;
      frame_q       <= frame_d;
      start_q       <= start_d;
    end
  end

endmodule

// File: tb/tb_rvvi_frame_builder.sv
// Directed-random bench: two builders (32- and 64-bit beats) checked against a byte-level frame model.
module tb_rvvi_frame_builder;
  import cvw::*;

  localparam int XLEN  = 64;
  localparam int MAXC  = 3;
  localparam int RW    = 72 + 5 * XLEN + MAXC * (XLEN + 16);
  localparam int FB    = (112 + RW + 7) / 8;
  localparam int DEPTH = 4;
  localparam int ITO   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] rvvi;
  logic          valid_a, valid_b, rdy_a, rdy_b;
  logic          stall_a, stall_b, wv_a, wv_b, wl_a, wl_b;
  logic [31:0]   wd_a;
  logic [63:0]   wd_b;
  logic [3:0]    ws_a;
  logic [7:0]    ws_b;
  logic [47:0]   src, dst;
  logic [15:0]   eth;
  logic [31:0]   delay, fc_a, fc_b;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            frames_a = 0;
  int            frames_b = 0;
  bit            stopped;
  logic [RW-1:0] mq[$];
  logic [RW-1:0] to_push[$];
  byte unsigned  eb [FB];
  logic [RW-1:0] rec;

  always #5 clk = ~clk;

  rvvi_frame_builder #(.P(CVW_RV64), .MAX_CSRS(MAXC), .DATA_W(32), .FIFO_DEPTH(DEPTH),
                       .INIT_TIME_OUT(32'd4)) dut_a (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .rvvi(rvvi), .valid(valid_a), .RVVIStall(stall_a),
    .RvviAxiWdata(wd_a), .RvviAxiWstrb(ws_a), .RvviAxiWlast(wl_a), .RvviAxiWvalid(wv_a),
    .RvviAxiWready(rdy_a), .SrcMac(src), .DstMac(dst), .EthType(eth),
    .InnerPktDelay(delay), .FrameCount(fc_a));

  rvvi_frame_builder #(.P(CVW_RV64), .MAX_CSRS(MAXC), .DATA_W(64), .FIFO_DEPTH(DEPTH),
                       .INIT_TIME_OUT(32'd4)) dut_b (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .rvvi(rvvi), .valid(valid_b), .RVVIStall(stall_b),
    .RvviAxiWdata(wd_b), .RvviAxiWstrb(ws_b), .RvviAxiWlast(wl_b), .RvviAxiWvalid(wv_b),
    .RvviAxiWready(rdy_b), .SrcMac(src), .DstMac(dst), .EthType(eth),
    .InnerPktDelay(delay), .FrameCount(fc_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_rec();
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < (RW + 31) / 32; i++) r = {r[RW-33:0], $urandom()};
    return r;
  endfunction

  task automatic rand_hdr();
    src = 48'({$urandom(), $urandom()});
    dst = 48'({$urandom(), $urandom()});
    eth = 16'($urandom());
  endtask

  // Frame as a little-endian byte string: SrcMac, DstMac, EthType, then the record.
  task automatic build_exp(input logic [RW-1:0] r);
    for (int i = 0; i < FB; i++) begin
      if (i < 6)       eb[i] = src[8*i +: 8];
      else if (i < 12) eb[i] = dst[8*(i-6) +: 8];
      else if (i < 14) eb[i] = eth[8*(i-12) +: 8];
      else             eb[i] = 8'(r >> (8 * (i - 14)));
    end
  endtask

  task automatic count_init();
    int n;
    n = 0;
    while (stall_a && n < 50) begin
      n++;
      @(posedge clk); @(negedge clk);
    end
    chk("init_stall_cycles", 64'(n), 64'(ITO));
    chk("init_stall_b", 64'(stall_b), 64'd0);
  endtask

  // Runs one DUT until nframes complete (or stop_beat reached), checking every beat and stall.
  task automatic run(input bit sel, input bit rnd, input bit hchg, input int nframes, input int stop_beat);
    int beat, done, cyc, gap, nb, idx;
    bit started, hold, rd, ended;
    logic [63:0] od, pd, ed;
    logic [7:0]  os, ps, es;
    logic        ov, ol, ost, pl, el;
    beat = 0; done = 0; cyc = 0; gap = -1; started = 0; hold = 0;
    pd = '0; ps = '0; pl = 1'b0; stopped = 0;
    nb = sel ? 8 : 4;
    while (done < nframes && cyc < 4000) begin
      rd = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sel) rdy_b = rd; else rdy_a = rd;
      valid_a = 1'b0; valid_b = 1'b0;
      if (to_push.size() > 0) begin
        rvvi = to_push[0];
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
      end
      ov  = sel ? wv_b : wv_a;
      od  = sel ? wd_b : {32'd0, wd_a};
      os  = sel ? ws_b : {4'd0, ws_a};
      ol  = sel ? wl_b : wl_a;
      ost = sel ? stall_b : stall_a;
      chk("stall", 64'(ost), 64'(mq.size() == DEPTH));
      if (hold) begin
        chk("hold_valid", 64'(ov), 64'd1);
        chk("hold_data", od, pd);
        chk("hold_strb", 64'(os), 64'(ps));
        chk("hold_last", 64'(ol), 64'(pl));
      end
      if (stop_beat >= 0 && ov && beat == stop_beat) begin
        stopped = 1;
        break;
      end
      if (!ov && gap >= 0) gap++;
      ended = 0;
      if (ov) begin
        if (!started) begin
          started = 1;
          build_exp(mq[0]);
          if (gap >= 0) chk("gap_cycles", 64'(gap), 64'(delay + 32'd2));
          gap = -1;
        end
        ed = '0; es = '0;
        for (int k = 0; k < nb; k++) begin
          idx = beat * nb + k;
          if (idx < FB) begin
            ed[8*k +: 8] = eb[idx];
            es[k] = 1'b1;
          end
        end
        el = ((beat + 1) * nb >= FB);
        if (rd) begin
          chk("beat_data", od, ed);
          chk("beat_strb", 64'(os), 64'(es));
          chk("beat_last", 64'(ol), 64'(el));
          if (el) begin
            done++; ended = 1; started = 0; beat = 0;
            void'(mq.pop_front());
            if (sel) frames_b++; else frames_a++;
          end else begin
            beat++;
          end
        end
        if (hchg && !(rd && el)) rand_hdr();
      end
      hold = ov && !rd;
      pd = od; ps = os; pl = ol;
      if (to_push.size() > 0 && !ost) mq.push_back(to_push.pop_front());
      if (ended) gap = (mq.size() > 0) ? 0 : -1;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    if (stop_beat < 0) begin
      chk("frames_done", 64'(done), 64'(nframes));
      chk("frame_count", sel ? 64'(fc_b) : 64'(fc_a), sel ? 64'(frames_b) : 64'(frames_a));
    end
    valid_a = 1'b0; valid_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; valid_a = 1'b0; valid_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    rvvi = '0; delay = 32'd0;
    rand_hdr();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(wv_a), 64'd0);
    chk("rst_last", 64'(wl_a), 64'd0);
    chk("rst_data", 64'(wd_a), 64'd0);
    chk("rst_strb", 64'(ws_a), 64'd0);
    chk("rst_stall", 64'(stall_a), 64'd1);
    chk("rst_count", 64'(fc_a), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_init();

    // Start latency from an idle, empty builder.
    rec = rand_rec();
    rvvi = rec; valid_a = 1'b1; rdy_a = 1'b1;
    chk("lat_stall", 64'(stall_a), 64'd0);
    @(posedge clk);
    mq.push_back(rec);
    @(negedge clk);
    valid_a = 1'b0;
    chk("lat_cycle0", 64'(wv_a), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("lat_cycle1", 64'(wv_a), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("lat_cycle2", 64'(wv_a), 64'd1);
    run(0, 0, 0, 1, -1);

    // 64-bit beats, single frame.
    to_push.push_back(rand_rec());
    run(1, 0, 0, 1, -1);

    // Back-to-back frames with a 5-cycle gap, random ready, header churn.
    delay = 32'd5;
    for (int i = 0; i < 3; i++) to_push.push_back(rand_rec());
    run(0, 1, 1, 3, -1);

    delay = 32'd0;
    for (int i = 0; i < 3; i++) to_push.push_back(rand_rec());
    run(0, 1, 0, 3, -1);

    // Fill the FIFO while the sink is stalled.
    delay = 32'd3; rdy_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rec = rand_rec();
      rvvi = rec; valid_a = 1'b1;
      chk("fifo_stall", 64'(stall_a), 64'(mq.size() >= DEPTH));
      if (!stall_a) mq.push_back(rec);
      else          to_push.push_back(rec);
      @(posedge clk); @(negedge clk);
    end
    valid_a = 1'b0;
    chk("fifo_full_stall", 64'(stall_a), 64'd1);
    chk("fifo_wait_valid", 64'(wv_a), 64'd1);
    run(0, 1, 1, 6, -1);

    for (int i = 0; i < 3; i++) to_push.push_back(rand_rec());
    run(1, 1, 1, 3, -1);

    // Reset in the middle of a frame.
    delay = 32'd2;
    to_push.push_back(rand_rec());
    run(0, 0, 0, 1, 10);
    chk("reached_beat10", 64'(stopped), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(wv_a), 64'd0);
    chk("mid_rst_last", 64'(wl_a), 64'd0);
    chk("mid_rst_data", 64'(wd_a), 64'd0);
    chk("mid_rst_strb", 64'(ws_a), 64'd0);
    chk("mid_rst_stall", 64'(stall_a), 64'd1);
    chk("mid_rst_count", 64'(fc_a), 64'd0);
    mq.delete(); to_push.delete();
    frames_a = 0; frames_b = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    count_init();
    to_push.push_back(rand_rec());
    run(0, 1, 0, 1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
